// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for a 2048-point streaming FFT core: one cfg beat, N packed sample beats, then wait for the output frame.
// Optional watchdog in FILL/DRAIN is enabled by defining FFT_FRAME_TIMEOUT_EN.
//   state | meaning
//   IDLE  | waiting for i_start
//   CFG   | one unconditional direction beat to the core
//   GAP   | CFG_GAP idle cycles before data
//   FILL  | samples pass straight through to the core, counting beats
//   DRAIN | waiting for the core's output tlast
//   DONE  | one-cycle completion pulse, then CFG (continuous) or IDLE
module fft_frame_sequencer #(
  parameter int LOGS_FFT_LEN = 11,
  parameter int INPUT_WIDTH  = 16,
  parameter int DATAIN_WIDTH = 16,
  parameter int CFG_GAP      = 2
) (
  input  logic                      i_aclk,
  input  logic                      i_aresetn,
  input  logic                      i_start,
  input  logic                      i_cont,
  input  logic                      i_fwd,
  input  logic                      i_smp_valid,
  input  logic [INPUT_WIDTH-1:0]    i_smp_data,
  output logic                      o_smp_ready,
  output logic                      o_cfg_tvalid,
  output logic                      o_cfg_tdata,
  output logic                      o_data_tvalid,
  output logic [2*DATAIN_WIDTH-1:0] o_data_tdata,
  output logic                      o_data_tlast,
  input  logic                      i_data_tready,
  input  logic                      i_out_tvalid,
  input  logic                      i_out_tlast,
  input  logic [2:0]                i_alm,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic [15:0]               o_frame_cnt,
  output logic                      o_err,
  output logic [2:0]                o_err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_GAP, S_FILL, S_DRAIN, S_DONE
  } state_t;

  localparam logic [LOGS_FFT_LEN-1:0] LAST_BEAT = '1;

  state_t                  state, state_nxt;
  logic [LOGS_FFT_LEN-1:0] beat_cnt;
  logic [7:0]              gap_cnt;
  logic                    fwd;
  logic                    beat_acc;
  logic                    timeout;
  logic [2:0]              alm_hit;
  logic signed [DATAIN_WIDTH-1:0] re_lane;

  assign beat_acc = (state == S_FILL) && i_smp_valid && i_data_tready;
  assign alm_hit  = (state != S_IDLE) ? i_alm : 3'b000;
  assign re_lane  = DATAIN_WIDTH'($signed(i_smp_data));

`ifdef FFT_FRAME_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        wd_run;
  logic        progress;

  assign wd_run   = (state == S_FILL) || (state == S_DRAIN);
  assign progress = beat_acc || ((state == S_DRAIN) && i_out_tvalid);
  // Fires on the 65535th consecutive cycle without progress.
  assign timeout  = wd_run && !progress && (wd_cnt == 16'd1);

  always_ff @(posedge i_aclk) begin
    if (!i_aresetn)              wd_cnt <= '1;
    else if (!wd_run || progress) wd_cnt <= '1;
    else if (wd_cnt != 16'd0)    wd_cnt <= wd_cnt - 16'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = S_CFG;
      S_CFG:   state_nxt = (CFG_GAP == 0) ? S_FILL : S_GAP;
      S_GAP:   if (gap_cnt == 8'd0) state_nxt = S_FILL;
      S_FILL:  if (beat_acc && (beat_cnt == LAST_BEAT)) state_nxt = S_DRAIN;
      S_DRAIN: if (i_out_tvalid && i_out_tlast) state_nxt = S_DONE;
      S_DONE:  state_nxt = i_cont ? S_CFG : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (timeout) state_nxt = S_IDLE;
  end

  always_comb begin
    o_cfg_tvalid  = 1'b0;
    o_cfg_tdata   = 1'b0;
    o_smp_ready   = 1'b0;
    o_data_tvalid = 1'b0;
    o_data_tdata  = '0;
    o_data_tlast  = 1'b0;
    o_frame_done  = 1'b0;
    o_busy        = (state != S_IDLE);
    case (state)
      S_CFG: begin
        o_cfg_tvalid = 1'b1;
        o_cfg_tdata  = fwd;
      end
      S_FILL: begin
        o_smp_ready   = i_data_tready;
        o_data_tvalid = i_smp_valid;
        o_data_tdata  = {{DATAIN_WIDTH{1'b0}}, re_lane};
        o_data_tlast  = (beat_cnt == LAST_BEAT);
      end
      S_DONE:  o_frame_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      fwd         <= 1'b0;
      gap_cnt     <= '0;
      beat_cnt    <= '0;
      o_frame_cnt <= '0;
      o_err       <= 1'b0;
      o_err_code  <= '0;
    end else begin
      if ((state == S_IDLE) && i_start) fwd <= i_fwd;

      if (state == S_CFG)                             gap_cnt <= 8'(CFG_GAP - 1);
      else if ((state == S_GAP) && (gap_cnt != 8'd0)) gap_cnt <= gap_cnt - 8'd1;

      // Counter wraps to 0 on the last beat, ready for the next frame.
      if (state != S_FILL) beat_cnt <= '0;
      else if (beat_acc)   beat_cnt <= beat_cnt + 1'b1;

      if (state == S_DONE) o_frame_cnt <= o_frame_cnt + 16'd1;

      if ((state == S_IDLE) && i_start) begin
        o_err      <= 1'b0;
        o_err_code <= '0;
      end else begin
        o_err      <= o_err | (|alm_hit) | timeout;
        o_err_code <= o_err_code | alm_hit | {timeout, 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer: frame-level reference model compared every cycle, plus literal checks per scenario.
module tb_fft_frame_sequencer;
  localparam int N   = 2048;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_start = 0, i_cont = 0, i_fwd = 0, i_smp_valid = 0;
  logic [15:0] i_smp_data = '0;
  logic        i_data_tready = 0, i_out_tvalid = 0, i_out_tlast = 0;
  logic [2:0]  i_alm = '0;
  logic        o_smp_ready, o_cfg_tvalid, o_cfg_tdata, o_data_tvalid, o_data_tlast;
  logic [31:0] o_data_tdata;
  logic        o_busy, o_frame_done, o_err;
  logic [15:0] o_frame_cnt;
  logic [2:0]  o_err_code;

  fft_frame_sequencer dut (
    .i_aclk(clk), .i_aresetn(rstn), .i_start(i_start), .i_cont(i_cont), .i_fwd(i_fwd),
    .i_smp_valid(i_smp_valid), .i_smp_data(i_smp_data), .o_smp_ready(o_smp_ready),
    .o_cfg_tvalid(o_cfg_tvalid), .o_cfg_tdata(o_cfg_tdata), .o_data_tvalid(o_data_tvalid),
    .o_data_tdata(o_data_tdata), .o_data_tlast(o_data_tlast), .i_data_tready(i_data_tready),
    .i_out_tvalid(i_out_tvalid), .i_out_tlast(i_out_tlast), .i_alm(i_alm), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt), .o_err(o_err), .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  bit cmp_en = 0;
  int vmode = 0, rmode = 0;
  bit spur = 0;
  int unsigned seed;

  // Frame-level model: a frame is "active" from its cfg cycle until the output tlast, then one done cycle.
  bit   m_act = 0, m_done = 0, m_fwd = 0, m_err = 0;
  int   m_age = 0, m_beats = 0, m_frame = 0, m_cnt = 0, m_stall = 0;
  logic [2:0] m_code = '0;

  // DUT-side observations for the per-scenario literal checks.
  int mon_cfg, mon_cfg_one, mon_beats, mon_tlast_cnt, mon_tlast_idx, mon_done, mon_first_valid;
  int mon_imag_nz, mon_gap;
  bit mon_saw8000;

  function automatic logic [15:0] smp_val(int frame, int idx);
    logic [31:0] h;
    if (idx == 5) return 16'h8000;
    h = seed + 32'(frame) * 32'd7919 + 32'(idx) * 32'd40503;
    return h[23:8];
  endfunction

  function automatic bit e_cfg();   return m_act && m_age == 0; endfunction
  function automatic bit e_fill();  return m_act && m_age >= 1 + GAP && m_beats < N; endfunction
  function automatic bit e_drain(); return m_act && m_beats == N; endfunction
  function automatic bit e_busy();  return m_act || m_done; endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit fill, drain, busy, prog;
    fill = e_fill(); drain = e_drain(); busy = e_busy();
    prog = (fill && i_smp_valid && i_data_tready) || (drain && i_out_tvalid);
    cyc++;
    if (!rstn) begin
      m_act = 0; m_done = 0; m_cnt = 0; m_err = 0; m_code = '0; m_beats = 0; m_stall = 0;
      return;
    end
    if (busy && i_alm != 3'b000) begin m_err = 1; m_code |= i_alm; end
    if (m_done) begin
      m_cnt = (m_cnt + 1) % 65536;
      m_done = 0;
      if (i_cont) begin m_act = 1; m_age = 0; m_beats = 0; m_frame++; end
    end else if (m_act) begin
      if (fill && i_smp_valid && i_data_tready) m_beats++;
      else if (drain && i_out_tvalid && i_out_tlast) begin m_act = 0; m_done = 1; end
      if (m_age < 1000) m_age++;
    end else if (i_start) begin
      m_act = 1; m_age = 0; m_beats = 0; m_fwd = i_fwd; m_err = 0; m_code = '0; m_frame++;
    end
`ifdef FFT_FRAME_TIMEOUT_EN
    if ((fill || drain) && !prog) m_stall++; else m_stall = 0;
    if (m_stall == 65535) begin m_act = 0; m_done = 0; m_err = 1; m_code |= 3'b100; m_stall = 0; end
`endif
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model, plus DUT-side monitors.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      logic [31:0] exp_data;
      exp_data = e_fill() ? {16'h0000, smp_val(m_frame, m_beats)} : 32'h0;
      check("busy",       32'(o_busy),        32'(e_busy()));
      check("cfg_tvalid", 32'(o_cfg_tvalid),  32'(e_cfg()));
      check("cfg_tdata",  32'(o_cfg_tdata),   32'(e_cfg() && m_fwd));
      check("smp_ready",  32'(o_smp_ready),   32'(e_fill() && i_data_tready));
      check("data_tvalid",32'(o_data_tvalid), 32'(e_fill() && i_smp_valid));
      check("data_tdata", o_data_tdata,       exp_data);
      check("data_tlast", 32'(o_data_tlast),  32'(e_fill() && m_beats == N - 1));
      check("frame_done", 32'(o_frame_done),  32'(m_done));
      check("frame_cnt",  32'(o_frame_cnt),   32'(m_cnt));
      check("err",        32'(o_err),         32'(m_err));
      check("err_code",   32'(o_err_code),    32'(m_code));
    end
    if (o_cfg_tvalid) begin mon_cfg++; if (o_cfg_tdata) mon_cfg_one++; end
    if (o_data_tvalid && mon_first_valid < 0) mon_first_valid = cyc;
    if (o_data_tvalid && o_smp_ready) begin
      if (o_data_tlast) begin mon_tlast_cnt++; mon_tlast_idx = mon_beats; end
      if (o_data_tdata[31:16] != 16'h0) mon_imag_nz++;
      if (o_data_tdata == 32'h0000_8000) mon_saw8000 = 1;
      mon_beats++;
    end
    if (o_frame_done) mon_done++;
    if (!o_busy && mon_done > 0 && mon_done < 3) mon_gap++;
  end

  task automatic mon_clear();
    mon_cfg = 0; mon_cfg_one = 0; mon_beats = 0; mon_tlast_cnt = 0; mon_tlast_idx = -1;
    mon_done = 0; mon_first_valid = -1; mon_imag_nz = 0; mon_gap = 0; mon_saw8000 = 0;
  endtask

  task automatic tick();
    int r;
    @(posedge clk);
    #2;
    i_start = 0;
    i_alm = '0;
    i_smp_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    case (rmode)
      0: i_data_tready = 1'b1;
      1: i_data_tready = (cyc % 3 != 0);
      2: i_data_tready = 1'($urandom_range(0, 1));
      default: i_data_tready = 1'b0;
    endcase
    i_smp_data = (m_act && m_beats < N) ? smp_val(m_frame, m_beats) : 16'($urandom);
    i_out_tvalid = 0; i_out_tlast = 0;
    if (e_drain()) begin
      r = $urandom_range(0, 3);
      i_out_tvalid = (r != 0);
      i_out_tlast = (r == 3);
    end else if (spur && e_fill() && $urandom_range(0, 39) == 0) begin
      i_out_tvalid = 1; i_out_tlast = 1;
    end
  endtask

  task automatic wait_idle(string name, int limit);
    int k = 0;
    while (e_busy() && k < limit) begin tick(); k++; end
    if (e_busy()) begin
      n_tests++; n_fail++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, limit);
    end
  endtask

  task automatic wait_beats(string name, int target, int limit);
    int k = 0;
    while (m_beats < target && k < limit) begin tick(); k++; end
    if (m_beats < target) begin
      n_tests++; n_fail++;
      $display("FAIL %s: beat count %0d after %0d cycles, expected %0d", name, m_beats, limit, target);
    end
  endtask

  task automatic do_reset();
    rstn = 0; tick(); tick(); rstn = 1; tick();
  endtask

  initial begin
    int start_cyc;
    seed = $urandom;
    mon_clear();
    // 1: basic forward frame, full throughput
    rstn = 0; tick(); cmp_en = 1; tick(); rstn = 1; tick();
    check("reset_frame_cnt", 32'(o_frame_cnt), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    mon_clear();
    i_fwd = 1; i_start = 1; start_cyc = cyc; tick();
    wait_idle("t1_frame", 10000);
    check("t1_cfg_beats", mon_cfg, 1);
    check("t1_cfg_fwd", mon_cfg_one, 1);
    check("t1_first_data_lat", mon_first_valid - start_cyc, 2 + GAP);
    check("t1_tlast_cnt", mon_tlast_cnt, 1);
    check("t1_tlast_idx", mon_tlast_idx, N - 1);
    check("t1_done_cnt", mon_done, 1);
    check("t1_frame_cnt", 32'(o_frame_cnt), 32'd1);

    // 2: sparse valid, tready low every third cycle, spurious output tlast in FILL
    vmode = 1; rmode = 1; spur = 1; mon_clear();
    i_fwd = 0; i_start = 1; tick();
    wait_idle("t2_frame", 30000);
    check("t2_beats", mon_beats, N);
    check("t2_imag_zero", mon_imag_nz, 0);
    check("t2_min_sample", 32'(mon_saw8000), 32'd1);
    check("t2_cfg_inv", mon_cfg_one, 0);
    check("t2_frame_cnt", 32'(o_frame_cnt), 32'd2);

    // 3: continuous mode for three frames, stray i_start while busy
    spur = 0; vmode = 0; rmode = 2;
    do_reset(); mon_clear();
    i_cont = 1; i_fwd = 1'($urandom_range(0, 1)); i_start = 1; tick();
    for (int k = 0; k < 40000 && e_busy(); k++) begin
      tick();
      if (m_cnt >= 2) i_cont = 0;
      if (e_busy() && $urandom_range(0, 99) == 0) i_start = 1;
    end
    i_cont = 0;
    wait_idle("t3_frames", 10000);
    check("t3_cfg_beats", mon_cfg, 3);
    check("t3_done_cnt", mon_done, 3);
    check("t3_no_idle_gap", mon_gap, 0);
    check("t3_frame_cnt", 32'(o_frame_cnt), 32'd3);

    // 4: one-cycle alarm during FILL
    vmode = 1; rmode = 0; mon_clear();
    i_fwd = 1; i_start = 1; tick();
    wait_beats("t4_fill", 100, 5000);
    i_alm = 3'b010; tick();
    wait_idle("t4_frame", 20000);
    check("t4_err", 32'(o_err), 32'd1);
    check("t4_err_code", 32'(o_err_code), 32'd2);
    check("t4_done_cnt", mon_done, 1);
    i_start = 1; tick();
    check("t4_err_clear", 32'(o_err), 32'd0);
    check("t4_code_clear", 32'(o_err_code), 32'd0);
    wait_idle("t4_frame2", 20000);

    // 5: reset mid-frame at beat 1000, then a clean frame
    vmode = 0; rmode = 0;
    i_start = 1; tick();
    wait_beats("t5_fill", 1000, 5000);
    rstn = 0; tick();
    check("t5_rst_outputs", {o_busy, o_cfg_tvalid, o_cfg_tdata, o_smp_ready, o_data_tvalid,
                             o_data_tlast, o_frame_done, o_err, o_err_code}, 32'd0);
    check("t5_rst_tdata", o_data_tdata, 32'd0);
    check("t5_rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    rstn = 1; mon_clear();
    i_start = 1; tick();
    wait_idle("t5_frame", 10000);
    check("t5_cfg_beats", mon_cfg, 1);
    check("t5_tlast_idx", mon_tlast_idx, N - 1);
    check("t5_frame_cnt", 32'(o_frame_cnt), 32'd1);

`ifdef FFT_FRAME_TIMEOUT_EN
    // 6: tready held low in FILL until the watchdog fires
    mon_clear();
    i_start = 1; tick();
    wait_beats("t6_fill", 10, 1000);
    rmode = 3;
    wait_idle("t6_timeout", 70000);
    rmode = 0;
    tick();
    check("t6_err", 32'(o_err), 32'd1);
    check("t6_code2", 32'(o_err_code[2]), 32'd1);
    check("t6_busy", 32'(o_busy), 32'd0);
    check("t6_no_done", mon_done, 0);
    check("t6_frame_cnt", 32'(o_frame_cnt), 32'd1);
`endif

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
